// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; the requester holds the master side.
interface serial_adder_if #(
  parameter int G = 32
);
  // Handshake: start is sampled only while busy=0; an accepted start begins an
  // operation, busy stays high until the result cycle ends, and done pulses for
  // exactly one cycle when sum/cout/ovf are updated. start while busy is dropped.
  logic         start;
  logic [G-1:0] a;
  logic [G-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [G-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf, dbg_state
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf, dbg_state
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// G cycles per operation with a start/busy/done handshake.
module serial_adder #(
  parameter int G = 32
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [G-1:0]  r_a;
  logic [G-1:0]  r_b;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic          r_a_msb;
  logic          r_b_msb;
  logic [G-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_done;

  logic          w_s;
  logic          w_carry;
  logic          w_last;
  logic          w_ovf;
  logic [G-1:0]  w_a_next;

  assign w_s     = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last  = (r_cnt == CW'(G - 1));

  // Sum bits are shifted into the top of the A register as its bits are consumed,
  // so after G shifts r_a holds the complete sum, LSB at bit 0.
  generate
    if (G == 1) begin : g_single
      assign w_a_next = w_s;
    end else begin : g_multi
      assign w_a_next = {w_s, r_a[G-1:1]};
    end
  endgenerate

  // The sum MSB produced on the final shift is w_s itself.
  assign w_ovf = (r_a_msb == r_b_msb) && (w_s != r_a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_a_msb <= bus.a[G-1];
            r_b_msb <= bus.b[G-1];
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a     <= w_a_next;
          r_b     <= r_b >> 1;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_a_next;
            r_cout  <= w_carry;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: G=8 directed cases plus random G=32 and G=1 runs,
// all checked every cycle against a timing/arithmetic reference model.
module tb_serial_adder;

  logic clk;
  logic rst8, rst32, rst1;

  serial_adder_if #(.G(8))  if8  ();
  serial_adder_if #(.G(32)) if32 ();
  serial_adder_if #(.G(1))  if1  ();

  serial_adder #(.G(8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(if8));
  serial_adder #(.G(32)) u_dut32 (.clk(clk), .rst(rst32), .bus(if32));
  serial_adder #(.G(1))  u_dut1  (.clk(clk), .rst(rst1),  .bus(if1));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- reference model ----------------
  int          gv [3] = '{8, 32, 1};
  longint      cyc = 0;
  bit          chk    [3];
  bit          act    [3];
  longint      acc    [3];
  longint      nfree  [3];
  int          nacc   [3];
  logic [31:0] p_sum  [3];
  bit          p_cout [3];
  bit          p_ovf  [3];
  bit          e_busy [3];
  bit          e_done [3];
  logic [31:0] e_sum  [3];
  bit          e_cout [3];
  bit          e_ovf  [3];

  // One clock edge: an accepted start at edge N yields results at edge N+G,
  // busy from N to N+G, and the next start can be taken at N+G+2.
  task automatic step(input int id, input bit r, input bit s,
                      input logic [31:0] a, input logic [31:0] b, input bit c);
    int          g;
    logic [31:0] m;
    logic [32:0] full;
    g = gv[id];
    m = (g == 32) ? 32'hFFFF_FFFF : ((32'd1 << g) - 32'd1);
    e_done[id] = 1'b0;
    if (r) begin
      act[id]    = 1'b0;
      e_busy[id] = 1'b0;
      e_sum[id]  = '0;
      e_cout[id] = 1'b0;
      e_ovf[id]  = 1'b0;
      nfree[id]  = cyc + 1;
      chk[id]    = 1'b1;
    end else begin
      if (act[id] && cyc == acc[id] + g) begin
        e_done[id] = 1'b1;
        e_sum[id]  = p_sum[id];
        e_cout[id] = p_cout[id];
        e_ovf[id]  = p_ovf[id];
      end
      if (act[id] && cyc == acc[id] + g + 1) begin
        act[id]    = 1'b0;
        e_busy[id] = 1'b0;
      end
      if (s && !act[id] && cyc >= nfree[id]) begin
        act[id]    = 1'b1;
        acc[id]    = cyc;
        full       = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
        p_sum[id]  = full[31:0] & m;
        p_cout[id] = full[g];
        p_ovf[id]  = (a[g-1] == b[g-1]) && (p_sum[id][g-1] != a[g-1]);
        nfree[id]  = cyc + g + 2;
        e_busy[id] = 1'b1;
        nacc[id]++;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    step(0, rst8,  if8.start,  32'(if8.a),  32'(if8.b),  if8.cin);
    step(1, rst32, if32.start, if32.a,      if32.b,      if32.cin);
    step(2, rst1,  if1.start,  32'(if1.a),  32'(if1.b),  if1.cin);
  end

  // ---------------- scoreboard ----------------
  task automatic cmp_cycle(input int id, input logic busy, input logic done,
                           input logic [31:0] sum, input logic cout, input logic ovf);
    if (chk[id]) begin
      n_vec++;
      if ({busy, done, sum, cout, ovf} !== {e_busy[id], e_done[id], e_sum[id], e_cout[id], e_ovf[id]}) begin
        n_miss++;
        $display("FAIL cycle_g%0d @%0d: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected busy=%b done=%b sum=%h cout=%b ovf=%b",
                 gv[id], cyc, busy, done, sum, cout, ovf,
                 e_busy[id], e_done[id], e_sum[id], e_cout[id], e_ovf[id]);
      end
    end
  endtask

  always @(negedge clk) begin
    cmp_cycle(0, if8.busy,  if8.done,  32'(if8.sum), if8.cout,  if8.ovf);
    cmp_cycle(1, if32.busy, if32.done, if32.sum,     if32.cout, if32.ovf);
    cmp_cycle(2, if1.busy,  if1.done,  32'(if1.sum), if1.cout,  if1.ovf);
  end

  task automatic lit(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_vec++;
    if (act_v !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  // ---------------- G=8 drivers ----------------
  task automatic wait_idle8();
    int guard = 0;
    while (if8.busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    lit("idle_wait8", 64'(guard >= 50), 64'(0));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp_cs, input logic exp_ovf, input string nm);
    int k;
    wait_idle8();
    if8.a = a; if8.b = b; if8.cin = c; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = ~a; if8.b = ~b; if8.cin = ~c;
    k = 0;
    while (!if8.done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    lit({nm, "_latency"}, 64'(k), 64'(8));
    lit({nm, "_cout_sum"}, 64'({if8.cout, if8.sum}), 64'(exp_cs));
    lit({nm, "_ovf"}, 64'(if8.ovf), 64'(exp_ovf));
  endtask

  task automatic seq8();
    int ndone, first, last, nd;
    op8(8'h3C, 8'h5A, 1'b0, 9'h096, 1'b1, "t1");
    op8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, "t2");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, "t3a");
    op8(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, "t3b");

    // start held high: back-to-back operations every G+2 cycles
    wait_idle8();
    if8.start = 1'b1;
    ndone = 0; first = -1; last = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom_range(0, 1));
      if (if8.done) begin
        if (first < 0) first = i;
        last = i;
        ndone++;
      end
    end
    if8.start = 1'b0;
    lit("t4_ndone", 64'(ndone), 64'(4));
    lit("t4_first", 64'(first), 64'(9));
    lit("t4_span",  64'(last - first), 64'(30));

    // reset on the 4th shift edge abandons the operation
    wait_idle8();
    if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    lit("t5_busy", 64'(if8.busy), 64'(0));
    lit("t5_done", 64'(if8.done), 64'(0));
    lit("t5_cout_sum", 64'({if8.cout, if8.sum}), 64'(0));
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done) nd++;
    end
    lit("t5_no_done", 64'(nd), 64'(0));
    op8(8'h01, 8'h02, 1'b0, 9'h003, 1'b0, "t5b");
  endtask

  // ---------------- random drivers ----------------
  task automatic rand32();
    int budget = 0;
    while (nacc[1] < 1000 && budget < 60000) begin
      @(posedge clk); #1;
      if32.start = ($urandom_range(0, 3) != 0);
      if32.a     = $urandom;
      if32.b     = $urandom;
      if32.cin   = 1'($urandom_range(0, 1));
      budget++;
    end
    if32.start = 1'b0;
    repeat (40) @(posedge clk);
    #1 lit("g32_ops", 64'(nacc[1]), 64'(1000));
  endtask

  task automatic rand1();
    int budget = 0;
    logic [31:0] r;
    while (nacc[2] < 1000 && budget < 20000) begin
      @(posedge clk); #1;
      r = $urandom;
      if1.start = ($urandom_range(0, 3) != 0);
      if1.a     = r[0];
      if1.b     = r[1];
      if1.cin   = r[2];
      budget++;
    end
    if1.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 lit("g1_ops", 64'(nacc[2]), 64'(1000));
  endtask

  // ---------------- main ----------------
  initial begin
    rst8 = 1'b1; rst32 = 1'b1; rst1 = 1'b1;
    if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0;
    if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
    if1.start  = 1'b0; if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0; rst32 = 1'b0; rst1 = 1'b0;
    lit("reset_outputs8", 64'({if8.busy, if8.done, if8.sum, if8.cout, if8.ovf}), 64'(0));
    lit("reset_outputs32", 64'({if32.busy, if32.done, if32.sum, if32.cout, if32.ovf}), 64'(0));
    lit("reset_state8", 64'(if8.dbg_state), 64'(0));
    fork
      seq8();
      rand32();
      rand1();
    join
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
